// File: rtl/rib_mailbox_pkg.sv
// ----------------------------------------------------------------------------
// rib_mailbox_pkg
//
// Shared definitions for the RIB inter-core mailbox: register offsets within a
// channel window, STAT/CTRL bit positions, reset values and the helper that
// turns a programmed threshold into the effective interrupt threshold.
//
// Optional feature macro: MAILBOX_THRESH_EN (programmable irq threshold).
// ----------------------------------------------------------------------------
package rib_mailbox_pkg;

    // Default number of entries per channel FIFO (power of two, >= 2).
    localparam int MBOX_DEPTH_DEFAULT = 8;

    // Register selected by addr_i[3:2] inside a channel window.
    typedef enum logic [1:0] {
        MBOX_PUSH = 2'd0,
        MBOX_HEAD = 2'd1,
        MBOX_STAT = 2'd2,
        MBOX_CTRL = 2'd3
    } mbox_reg_e;

    // STAT register bit positions.
    localparam int MBOX_STAT_EMPTY = 0;
    localparam int MBOX_STAT_FULL  = 1;
    localparam int MBOX_STAT_COUNT = 8;
    localparam int MBOX_STAT_OVF   = 16;

    // CTRL register bit positions.
    localparam int MBOX_CTRL_IRQ_EN   = 0;
    localparam int MBOX_CTRL_THRESH   = 8;
    localparam int MBOX_CTRL_THRESH_W = 4;
    localparam int MBOX_CTRL_OVF_CLR  = 16;

    // Threshold value loaded by reset.
    localparam logic [MBOX_CTRL_THRESH_W-1:0] MBOX_THRESH_RESET = 4'd1;

    // A programmed threshold of zero would make the interrupt fire on an
    // empty FIFO, which is never useful, so zero behaves like one.
    function automatic logic [MBOX_CTRL_THRESH_W-1:0] eff_thresh(
        input logic [MBOX_CTRL_THRESH_W-1:0] thresh
    );
        return (thresh == '0) ? MBOX_CTRL_THRESH_W'(1) : thresh;
    endfunction

endpackage

// File: rtl/rib_mailbox_fifo.sv
// ----------------------------------------------------------------------------
// mailbox_fifo
//
// One message channel of the mailbox: a DEPTH x 32 bit FIFO with a sticky
// overflow flag. Push and pop never arrive together because the mailbox has a
// single write port, but the logic still resolves that case cleanly.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active low
//   push     in   enqueue wdata (dropped and ovf set when full)
//   pop      in   discard head entry (ignored when empty)
//   wdata    in   32-bit word to enqueue
//   head     out  current head word, 0 when empty
//   count    out  number of stored words, 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
//   ovf      out  sticky overflow flag
//   ovf_clr  in   clear overflow flag
// ----------------------------------------------------------------------------
module mailbox_fifo
    import rib_mailbox_pkg::*;
#(
    parameter int DEPTH = MBOX_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    input  logic          ovf_clr
);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign head  = empty ? 32'h0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        // Pointers are exactly log2(DEPTH) wide, so the increment wraps
        // modulo DEPTH on its own.
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        // A lost word outranks a clear so an overflow is never missed.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push && full) begin
            ovf_d = 1'b1;
        end
    end

    // Control state is reset; a reset therefore discards queued messages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Message storage is deliberately left unreset; empty hides stale words.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rib_mailbox.sv
// ----------------------------------------------------------------------------
// rib_mailbox
//
// RIB slave providing two 32-bit message channels between the two cores:
// channel 0 carries core0 -> core1, channel 1 carries core1 -> core0.
// irq_o[0] is wired to core1 int_i[0], irq_o[1] to core0 int_i[1].
//
// Register window per channel (channel = addr_i[4], register = addr_i[3:2]):
//   0x0 PUSH  write pushes data_i, reads 0
//   0x4 HEAD  read returns head (0 when empty), any write pops
//   0x8 STAT  [0] empty, [1] full, [8+:CW] count, [16] ovf sticky
//   0xC CTRL  [0] irq_en, [11:8] thresh, write with data_i[16]=1 clears ovf
//
// Optional feature macro: MAILBOX_THRESH_EN
//   defined   : CTRL[11:8] is a writable interrupt threshold (0 acts as 1)
//   undefined : threshold fixed at 1, CTRL[11:8] reads 0
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous reset, active low
//   we_i    in   write strobe, one access per high cycle
//   addr_i  in   byte address, only [4:2] decoded
//   data_i  in   write data
//   data_o  out  combinational read data
//   irq_o   out  registered level interrupt per channel
// ----------------------------------------------------------------------------
module rib_mailbox
    import rib_mailbox_pkg::*;
#(
    parameter int DEPTH = MBOX_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [1:0]  irq_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          ch_sel;
    mbox_reg_e     reg_sel;
    logic [1:0]    ch_hit;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    ovf_clr;
    logic [1:0]    ctrl_we;

    logic [31:0]   head  [2];
    logic [CW-1:0] count [2];
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    ovf;

    logic [1:0]    irq_en_q, irq_en_d;
    logic [1:0]    irq_q, irq_d;
`ifdef MAILBOX_THRESH_EN
    logic [1:0][MBOX_CTRL_THRESH_W-1:0] thresh_q, thresh_d;
`endif

    // Address bits outside [4:2] and the undecoded data bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], data_i};

    assign ch_sel  = addr_i[4];
    assign reg_sel = mbox_reg_e'(addr_i[3:2]);
    assign ch_hit  = {ch_sel, ~ch_sel};

    // Write decode. There is no read strobe on the RIB slave port, so every
    // state change, including pop, must come from a write.
    always_comb begin
        push    = '0;
        pop     = '0;
        ovf_clr = '0;
        ctrl_we = '0;
        if (we_i) begin
            case (reg_sel)
                MBOX_PUSH: push    = ch_hit;
                MBOX_HEAD: pop     = ch_hit;
                MBOX_CTRL: begin
                    ctrl_we = ch_hit;
                    if (data_i[MBOX_CTRL_OVF_CLR]) begin
                        ovf_clr = ch_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    mailbox_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push    (push[0]),
        .pop     (pop[0]),
        .wdata   (data_i),
        .head    (head[0]),
        .count   (count[0]),
        .full    (full[0]),
        .empty   (empty[0]),
        .ovf     (ovf[0]),
        .ovf_clr (ovf_clr[0])
    );

    mailbox_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push    (push[1]),
        .pop     (pop[1]),
        .wdata   (data_i),
        .head    (head[1]),
        .count   (count[1]),
        .full    (full[1]),
        .empty   (empty[1]),
        .ovf     (ovf[1]),
        .ovf_clr (ovf_clr[1])
    );

    // CTRL register updates and next interrupt level. The interrupt is
    // computed from the current (registered) count, so irq_o trails count
    // by one cycle.
    always_comb begin
        irq_en_d = irq_en_q;
        irq_d    = '0;
`ifdef MAILBOX_THRESH_EN
        thresh_d = thresh_q;
`endif
        for (int c = 0; c < 2; c++) begin
            if (ctrl_we[c]) begin
                irq_en_d[c] = data_i[MBOX_CTRL_IRQ_EN];
`ifdef MAILBOX_THRESH_EN
                thresh_d[c] = data_i[MBOX_CTRL_THRESH +: MBOX_CTRL_THRESH_W];
`endif
            end
`ifdef MAILBOX_THRESH_EN
            // Counts never exceed DEPTH, so thresholds above it never fire.
            irq_d[c] = irq_en_q[c] &&
                       (32'(count[c]) >= 32'(eff_thresh(thresh_q[c])));
`else
            irq_d[c] = irq_en_q[c] && !empty[c];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q <= '0;
            irq_q    <= '0;
`ifdef MAILBOX_THRESH_EN
            thresh_q <= {2{MBOX_THRESH_RESET}};
`endif
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
`ifdef MAILBOX_THRESH_EN
            thresh_q <= thresh_d;
`endif
        end
    end

    assign irq_o = irq_q;

    // Read mux: purely combinational from the address and current state,
    // with no side effects on any register.
    always_comb begin
        data_o = '0;
        case (reg_sel)
            MBOX_HEAD: data_o = head[ch_sel];
            MBOX_STAT: begin
                data_o[MBOX_STAT_EMPTY]         = empty[ch_sel];
                data_o[MBOX_STAT_FULL]          = full[ch_sel];
                data_o[MBOX_STAT_COUNT +: CW]   = count[ch_sel];
                data_o[MBOX_STAT_OVF]           = ovf[ch_sel];
            end
            MBOX_CTRL: begin
                data_o[MBOX_CTRL_IRQ_EN] = irq_en_q[ch_sel];
`ifdef MAILBOX_THRESH_EN
                data_o[MBOX_CTRL_THRESH +: MBOX_CTRL_THRESH_W] = thresh_q[ch_sel];
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rib_mailbox.sv
// ----------------------------------------------------------------------------
// tb_rib_mailbox
//
// Directed bench for rib_mailbox (DEPTH = 8). Reads are announced to a
// checker process together with their hand-computed expected values.
// Honours MAILBOX_THRESH_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_rib_mailbox;

    localparam logic [31:0] A_PUSH0 = 32'h4000_0000;
    localparam logic [31:0] A_HEAD0 = 32'h4000_0004;
    localparam logic [31:0] A_STAT0 = 32'h4000_0008;
    localparam logic [31:0] A_CTRL0 = 32'h4000_000C;
    localparam logic [31:0] A_PUSH1 = 32'h4000_0010;
    localparam logic [31:0] A_HEAD1 = 32'h4000_0014;
    localparam logic [31:0] A_STAT1 = 32'h4000_0018;
    localparam logic [31:0] A_CTRL1 = 32'h4000_001C;
    // Aliases ch0 PUSH through the ignored address bits.
    localparam logic [31:0] A_PUSH0_ALIAS = 32'hFFFF_FFE3;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [1:0]  irq_o;

    logic        rd_req;
    int          n_checks;
    int          n_errors;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  irq;
        bit          chk_irq;
    } exp_t;

    exp_t exp_q[$];

    rib_mailbox #(
        .DEPTH (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .irq_o  (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One write access: driven at a falling edge, taken on the next rising
    // edge, released at the following falling edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        we_i   = 1'b1;
        addr_i = addr;
        data_i = data;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    // Present a read address and announce the expected response.
    task automatic expectRead(input string name, input logic [31:0] addr,
                              input logic [31:0] data, input bit chk_irq,
                              input logic [1:0] irq);
        exp_t e;
        we_i   = 1'b0;
        addr_i = addr;
        #1;
        e.name    = name;
        e.data    = data;
        e.irq     = irq;
        e.chk_irq = chk_irq;
        exp_q.push_back(e);
        rd_req = 1'b1;
        #1;
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if (data_o !== e.data) begin
            n_errors++;
            $display("[TB] FAIL %s: data_o=%h expected %h", e.name, data_o, e.data);
        end
        if (e.chk_irq) begin
            n_checks++;
            if (irq_o !== e.irq) begin
                n_errors++;
                $display("[TB] FAIL %s_irq: irq_o=%b expected %b", e.name, irq_o, e.irq);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge rd_req);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_read: data_o=%h expected no read", data_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("[TB] FAIL watchdog: time=%0t expected completion before limit", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rd_req   = 1'b0;
        rst      = 1'b0;
        we_i     = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        expectRead("rst_stat0", A_STAT0, 32'h0000_0001, 1, 2'b00);
        expectRead("rst_stat1", A_STAT1, 32'h0000_0001, 0, 2'b00);
        expectRead("rst_head0", A_HEAD0, 32'h0, 0, 2'b00);
`ifdef MAILBOX_THRESH_EN
        expectRead("rst_ctrl0", A_CTRL0, 32'h0000_0100, 0, 2'b00);
`else
        expectRead("rst_ctrl0", A_CTRL0, 32'h0000_0000, 0, 2'b00);
`endif

        // 1: basic ordering, PUSH reads 0, STAT writes ignored
        applyStimulus(A_PUSH0, 32'hA5A5_0001);
        applyStimulus(A_PUSH0_ALIAS, 32'hA5A5_0002);
        expectRead("t1_stat0", A_STAT0, 32'h0000_0200, 0, 2'b00);
        expectRead("t1_push_rd", A_PUSH0, 32'h0, 0, 2'b00);
        applyStimulus(A_STAT0, 32'hFFFF_FFFF);
        expectRead("t1_stat_ro", A_STAT0, 32'h0000_0200, 0, 2'b00);
        expectRead("t1_head_a", A_HEAD0, 32'hA5A5_0001, 0, 2'b00);
        expectRead("t1_head_a_again", A_HEAD0, 32'hA5A5_0001, 0, 2'b00);
        applyStimulus(A_HEAD0, 32'h0);
        expectRead("t1_head_b", A_HEAD0, 32'hA5A5_0002, 0, 2'b00);
        applyStimulus(A_HEAD0, 32'h0);
        expectRead("t1_stat_empty", A_STAT0, 32'h0000_0001, 0, 2'b00);

        // 2: overflow on ninth push, ovf clear, ninth word lost
        for (int i = 0; i < 9; i++) begin
            applyStimulus(A_PUSH0, 32'h0000_0100 + 32'(i));
        end
        expectRead("t2_stat_ovf", A_STAT0, 32'h0001_0802, 0, 2'b00);
        applyStimulus(A_CTRL0, 32'h0001_0000);
        expectRead("t2_stat_clr", A_STAT0, 32'h0000_0802, 0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            expectRead($sformatf("t2_head%0d", i), A_HEAD0, 32'h0000_0100 + 32'(i), 0, 2'b00);
            applyStimulus(A_HEAD0, 32'h0);
        end
        expectRead("t2_stat_drained", A_STAT0, 32'h0000_0001, 0, 2'b00);
        expectRead("t2_head_empty", A_HEAD0, 32'h0, 0, 2'b00);

        // 3: pop on empty channel 1
        applyStimulus(A_HEAD1, 32'h0000_1234);
        expectRead("t3_stat1", A_STAT1, 32'h0000_0001, 1, 2'b00);
        expectRead("t3_head1", A_HEAD1, 32'h0, 1, 2'b00);

        // 4: interrupt timing on channel 0
        applyStimulus(A_CTRL0, 32'h0000_0001);
        applyStimulus(A_PUSH0, 32'hCAFE_0000);
        expectRead("t4_cnt1", A_STAT0, 32'h0000_0100, 1, 2'b00);
        expectRead("t4_irq_on", A_STAT0, 32'h0000_0100, 1, 2'b01);
        applyStimulus(A_HEAD0, 32'h0);
        expectRead("t4_pop_lag", A_STAT0, 32'h0000_0001, 1, 2'b01);
        expectRead("t4_irq_off", A_STAT0, 32'h0000_0001, 1, 2'b00);
        // clearing irq_en
        applyStimulus(A_PUSH0, 32'hCAFE_0001);
        expectRead("t4_re_lag", A_STAT0, 32'h0000_0100, 1, 2'b00);
        expectRead("t4_re_on", A_STAT0, 32'h0000_0100, 1, 2'b01);
        applyStimulus(A_CTRL0, 32'h0000_0000);
        expectRead("t4_en_clr_lag", A_CTRL0, 32'h0, 1, 2'b01);
        expectRead("t4_en_clr_off", A_STAT0, 32'h0000_0100, 1, 2'b00);
        applyStimulus(A_HEAD0, 32'h0);
        // channel 1 interrupt lands on irq_o[1]
        applyStimulus(A_CTRL1, 32'h0000_0001);
        applyStimulus(A_PUSH1, 32'hBEEF_0001);
        expectRead("t4_ch1_lag", A_STAT1, 32'h0000_0100, 1, 2'b00);
        expectRead("t4_ch1_on", A_HEAD1, 32'hBEEF_0001, 1, 2'b10);
        expectRead("t4_ch0_quiet", A_STAT0, 32'h0000_0001, 1, 2'b10);
        applyStimulus(A_HEAD1, 32'h0);
        applyStimulus(A_CTRL1, 32'h0000_0000);
        expectRead("t4_ch1_off", A_STAT1, 32'h0000_0001, 1, 2'b00);

        // 5: three fill/drain rounds across pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(A_PUSH0, 32'(r * 8 + i));
            end
            expectRead($sformatf("t5_full_r%0d", r), A_STAT0, 32'h0000_0802, 0, 2'b00);
            for (int i = 0; i < 8; i++) begin
                expectRead($sformatf("t5_head_r%0d_%0d", r, i), A_HEAD0, 32'(r * 8 + i), 0, 2'b00);
                applyStimulus(A_HEAD0, 32'h0);
            end
            expectRead($sformatf("t5_empty_r%0d", r), A_STAT0, 32'h0000_0001, 0, 2'b00);
        end

        // 6: threshold, then asynchronous reset mid-stream
        applyStimulus(A_CTRL0, 32'h0000_0401);
`ifdef MAILBOX_THRESH_EN
        expectRead("t6_ctrl0", A_CTRL0, 32'h0000_0401, 1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(A_PUSH0, 32'h0000_6000 + 32'(i));
        end
        expectRead("t6_cnt3", A_STAT0, 32'h0000_0300, 1, 2'b00);
        expectRead("t6_cnt3_hold", A_STAT0, 32'h0000_0300, 1, 2'b00);
        applyStimulus(A_PUSH0, 32'h0000_6003);
        expectRead("t6_cnt4_lag", A_STAT0, 32'h0000_0400, 1, 2'b00);
        expectRead("t6_cnt4_on", A_STAT0, 32'h0000_0400, 1, 2'b01);
`else
        expectRead("t6_ctrl0", A_CTRL0, 32'h0000_0001, 1, 2'b00);
        applyStimulus(A_PUSH0, 32'h0000_6000);
        expectRead("t6_cnt1_lag", A_STAT0, 32'h0000_0100, 1, 2'b00);
        expectRead("t6_cnt1_on", A_STAT0, 32'h0000_0100, 1, 2'b01);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(A_PUSH0, 32'h0000_6000 + 32'(i));
        end
        expectRead("t6_cnt4_on", A_STAT0, 32'h0000_0400, 1, 2'b01);
`endif
        rst = 1'b0;
        expectRead("t6_rst_stat0", A_STAT0, 32'h0000_0001, 1, 2'b00);
`ifdef MAILBOX_THRESH_EN
        expectRead("t6_rst_ctrl0", A_CTRL0, 32'h0000_0100, 1, 2'b00);
`else
        expectRead("t6_rst_ctrl0", A_CTRL0, 32'h0000_0000, 1, 2'b00);
`endif
        rst = 1'b1;
        expectRead("t6_post_stat0", A_STAT0, 32'h0000_0001, 1, 2'b00);
        expectRead("t6_post_head0", A_HEAD0, 32'h0, 1, 2'b00);
        expectRead("t6_post_stat1", A_STAT1, 32'h0000_0001, 1, 2'b00);

        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL pending_reads: %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
